// File: rtl/aud_pkg.sv
// Shared definitions for the AUD remote-memory-monitor target: state codes,
// command bit positions, access size codes, status nibbles and the
// size-to-nibble-count helpers.
package aud_pkg;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CMD    = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_WDATA  = 4'd3;
  localparam logic [3:0] S_TURN   = 4'd4;
  localparam logic [3:0] S_WAIT   = 4'd5;
  localparam logic [3:0] S_STATUS = 4'd6;
  localparam logic [3:0] S_RDATA  = 4'd7;
  localparam logic [3:0] S_END    = 4'd8;
  localparam logic [3:0] S_SKIP   = 4'd9;
  localparam logic [3:0] S_DRAIN  = 4'd10;

  localparam int CMD_VALID = 3;
  localparam int CMD_WRITE = 2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;
  // Reserved size: accepted on the link but never reaches the bus.
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam logic [3:0] ST_BUSY    = 4'b0000;
  localparam logic [3:0] ST_READY   = 4'b0001;
  localparam logic [3:0] ST_BUSERR  = 4'b0011;
  localparam logic [3:0] ST_TIMEOUT = 4'b0101;

  // Number of data nibbles carried for a given size code.
  function automatic logic [3:0] nibbles(input logic [1:0] size);
    case (size)
      SZ_BYTE: nibbles = 4'd2;
      SZ_WORD: nibbles = 4'd4;
      SZ_LONG: nibbles = 4'd8;
      default: nibbles = 4'd8;
    endcase
  endfunction

  // Index of the final data nibble for a given size code.
  function automatic logic [2:0] last_nib(input logic [1:0] size);
    logic [3:0] n;
    n = nibbles(size) - 4'd1;
    last_nib = n[2:0];
  endfunction

endpackage

// File: rtl/aud_nibble_sreg.sv
// 32-bit register that is filled one nibble at a time (or loaded whole)
// and read back one nibble at a time, selected by a 3-bit index.
module aud_nibble_sreg
  import aud_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        ld_all,
  input  logic [31:0] all_i,
  input  logic        wr_nib,
  input  logic [2:0]  idx,
  input  logic [3:0]  nib_i,
  output logic [3:0]  nib_o,
  output logic [31:0] val_o
);

  logic [31:0] val_q, val_d;

  // Next value: clear wins over a whole-word load, which wins over a nibble write.
  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (ld_all) begin
      val_d = all_i;
    end else if (wr_nib) begin
      val_d[{idx, 2'b00} +: 4] = nib_i;
    end
  end

  // Register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign nib_o = val_q[{idx, 2'b00} +: 4];
  assign val_o = val_q;

endmodule

// File: rtl/aud_rmm_target.sv
// AUD remote-memory-monitor target: deserialises command/address/write data
// from the nibble link, performs one req/ack memory access, turns the bus
// around and returns a status nibble plus read data.
// Optional: define AUD_RMM_TARGET_TIMEOUT_EN to abandon a memory access
// after TIMEOUT_CYCLES cycles without mem_ack (status 0101).
module aud_rmm_target
  import aud_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        aud_ck,
  input  logic        rst,
  input  logic        aud_nsync,
  input  logic [3:0]  aud_data_i,
  output logic [3:0]  aud_data_o,
  output logic        aud_data_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic        busy
);

  logic [3:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [1:0] size_q, size_d;
  logic       req_q, req_d;
  logic       oe_q, oe_d;
  logic [3:0] dout_q, dout_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       rd_ok_q, rd_ok_d;

  logic        ack_now, tmo_hit;
  logic        addr_wr, wd_wr, wd_clr, rd_ld;
  logic [2:0]  rd_idx;
  logic [3:0]  rd_nib;
  logic [3:0]  unused_addr_nib, unused_wdata_nib;
  logic [31:0] unused_rdata_val;

  // An acknowledge only counts while a request is actually outstanding.
  assign ack_now = mem_ack && req_q;

  // Read-data nibble to present on the next edge: nibble 0 when leaving
  // STATUS, otherwise the one after the nibble currently on the pins.
  assign rd_idx = (state_q == S_RDATA) ? (cnt_q + 3'd1) : 3'd0;

`ifdef AUD_RMM_TARGET_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_q, tmo_d;

  // Timeout counter: cleared in TURN, counts every WAIT/DRAIN cycle.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_TURN) tmo_d = '0;
    else if (state_q == S_WAIT || state_q == S_DRAIN) tmo_d = tmo_q + 32'd1;
  end

  // Timeout counter register.
  always_ff @(posedge aud_ck or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end

  assign tmo_hit = req_q && !ack_now && (tmo_q == TMO_LAST) &&
                   (state_q == S_WAIT || state_q == S_DRAIN);
`else
  assign tmo_hit = 1'b0;
`endif

  // Link/bus sequencer: next state, counters, request and pin drive.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    req_d   = req_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    err_d   = err_q;
    done_d  = done_q;
    rd_ok_d = rd_ok_q;
    addr_wr = 1'b0;
    wd_wr   = 1'b0;
    wd_clr  = 1'b0;
    rd_ld   = 1'b0;

    if (ack_now) req_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!aud_nsync) state_d = S_CMD;
      end
      S_CMD: begin
        if (aud_nsync) begin
          state_d = S_IDLE;
        end else if (!aud_data_i[CMD_VALID]) begin
          state_d = S_SKIP;
        end else begin
          we_d    = aud_data_i[CMD_WRITE];
          size_d  = aud_data_i[1:0];
          cnt_d   = 3'd0;
          wd_clr  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (aud_nsync) begin
          state_d = S_IDLE;
        end else begin
          addr_wr = 1'b1;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if (we_q) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_TURN;
              req_d   = (size_q != SZ_RSVD);
              done_d  = 1'b0;
              err_d   = 1'b0;
            end
          end
        end
      end
      S_WDATA: begin
        if (aud_nsync) begin
          state_d = S_IDLE;
        end else begin
          wd_wr = 1'b1;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == last_nib(size_q)) begin
            state_d = S_TURN;
            req_d   = (size_q != SZ_RSVD);
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      S_TURN: begin
        if (ack_now) begin
          rd_ld  = 1'b1;
          err_d  = mem_err;
          done_d = 1'b1;
        end
        if (aud_nsync) begin
          state_d = (req_q && !ack_now) ? S_DRAIN : S_IDLE;
        end else begin
          state_d = S_WAIT;
          oe_d    = 1'b1;
          dout_d  = ST_BUSY;
        end
      end
      S_WAIT: begin
        if (ack_now) begin
          rd_ld  = 1'b1;
          err_d  = mem_err;
          done_d = 1'b1;
        end
        if (aud_nsync) begin
          oe_d = 1'b0;
          if (req_q && !ack_now && !tmo_hit) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end else if ((size_q == SZ_RSVD) || tmo_hit || ack_now || done_q) begin
          state_d = S_STATUS;
          req_d   = 1'b0;
          if (size_q == SZ_RSVD) dout_d = ST_BUSERR;
          else if (ack_now)      dout_d = mem_err ? ST_BUSERR : ST_READY;
          else if (done_q)       dout_d = err_q ? ST_BUSERR : ST_READY;
          else                   dout_d = ST_TIMEOUT;
          rd_ok_d = !we_q && (dout_d == ST_READY);
        end
      end
      S_STATUS: begin
        if (rd_ok_q) begin
          state_d = S_RDATA;
          cnt_d   = 3'd0;
          dout_d  = rd_nib;
        end else begin
          state_d = S_END;
          oe_d    = 1'b0;
        end
      end
      S_RDATA: begin
        if (cnt_q == last_nib(size_q)) begin
          state_d = S_END;
          oe_d    = 1'b0;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          dout_d = rd_nib;
        end
      end
      S_END, S_SKIP: begin
        oe_d = 1'b0;
        if (aud_nsync) state_d = S_IDLE;
      end
      S_DRAIN: begin
        oe_d = 1'b0;
        if (ack_now || tmo_hit || !req_q) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        oe_d    = 1'b0;
      end
    endcase

    if (!oe_d) dout_d = '0;
  end

  // Control and pin registers.
  always_ff @(posedge aud_ck or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      req_q   <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      req_q   <= req_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  aud_nibble_sreg u_addr (
    .clk    (aud_ck),
    .rst    (rst),
    .clr    (1'b0),
    .ld_all (1'b0),
    .all_i  (32'h0),
    .wr_nib (addr_wr),
    .idx    (cnt_q),
    .nib_i  (aud_data_i),
    .nib_o  (unused_addr_nib),
    .val_o  (mem_addr)
  );

  aud_nibble_sreg u_wdata (
    .clk    (aud_ck),
    .rst    (rst),
    .clr    (wd_clr),
    .ld_all (1'b0),
    .all_i  (32'h0),
    .wr_nib (wd_wr),
    .idx    (cnt_q),
    .nib_i  (aud_data_i),
    .nib_o  (unused_wdata_nib),
    .val_o  (mem_wdata)
  );

  aud_nibble_sreg u_rdata (
    .clk    (aud_ck),
    .rst    (rst),
    .clr    (1'b0),
    .ld_all (rd_ld),
    .all_i  (mem_rdata),
    .wr_nib (1'b0),
    .idx    (rd_idx),
    .nib_i  (4'h0),
    .nib_o  (rd_nib),
    .val_o  (unused_rdata_val)
  );

  assign aud_data_o  = dout_q;
  assign aud_data_oe = oe_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_size    = size_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/aud_rmm_target.md
Name: aud_rmm_target

Overview:
- Target (responder) end of the AUD remote-memory-monitor nibble link; the other end is the existing initiator.
- Deserialises command, address and write data from aud_data.
- Issues one access on a simple req/ack memory master port.
- Turns the bus around and returns the status nibble, plus read data for reads.
- Sits between the AUD pins (tristate in top level) and the on-chip memory bus.

Parameters:
- TIMEOUT_CYCLES, 1024: aud_ck cycles to wait for mem_ack before an error status; used only with the optional feature.

Ports:
- aud_ck  in  1  link clock; all logic on posedge
- rst  in  1  reset
- aud_nsync  in  1  frame strobe from initiator, low = transaction active
- aud_data_i  in  4  sampled pin nibble
- aud_data_o  out  4  nibble driven by target
- aud_data_oe  out  1  target drive enable for pins
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_size  out  2  0 byte, 1 word, 2 long
- mem_addr  out  32  access address
- mem_wdata  out  32  write data, zero-extended
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion
- mem_err  in  1  bus error, qualified by mem_ack
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: rst is asynchronous, active-high. All outputs go to 0 (aud_data_oe=0, mem_req=0, busy=0), state=IDLE, counter=0.
- Sampling: aud_nsync and aud_data_i are sampled on posedge aud_ck. aud_data_o and aud_data_oe are registered on posedge; the initiator samples on negedge.
- Nibble counts: N = 2<<size, giving 2, 4 or 8 nibbles. All fields go LSB nibble first, nibble k <-> bits [4k+3:4k].
- IDLE: nsync sampled 0 -> CMD. The lead-in nibble (0000) sampled in the same cycle is ignored.
- CMD: sample {d3,d2,size}.
  - d3=0: -> SKIP.
  - Otherwise latch we=d2 and size, counter=0, -> ADDR.
- ADDR: 8 nibbles into mem_addr. After nibble 7:
  - write -> WDATA, counter=0;
  - read -> TURN.
- WDATA: N nibbles into mem_wdata; the upper bits are cleared at CMD. After the last nibble -> TURN.
- TURN:
  - One cycle with aud_data_oe=0 (bus gap).
  - mem_req is asserted from TURN entry, unless size=3.
  - -> WAIT, with aud_data_oe=1 and aud_data_o=0000 from the next posedge.
- WAIT: drive 0000 (busy) until mem_ack.
  - On mem_ack, deassert mem_req in the same edge and capture mem_rdata.
  - Drive status for exactly 1 cycle: 0001 (ready), or 0011 if mem_err.
  - -> STATUS.
- STATUS:
  - Read without error: -> RDATA, counter=0.
  - Otherwise aud_data_oe=0, -> END.
- RDATA: drive captured rdata nibbles 0..N-1, one per cycle. After the last -> aud_data_oe=0, -> END.
- END: wait for nsync sampled 1 -> IDLE. If already 1, leave next cycle.
- SKIP: aud_data_oe=0, no memory access; -> IDLE when nsync sampled 1.
- size=3:
  - The command is accepted. A write consumes 8 data nibbles.
  - No mem_req is issued; WAIT lasts 1 cycle, then status 0011.
- nsync rises in CMD/ADDR/WDATA/TURN (abort):
  - No request pending: -> IDLE next cycle, outputs released.
  - In WAIT with mem_req pending: go to DRAIN. Keep mem_req until mem_ack, discard the result, aud_data_oe=0, then IDLE.
- nsync rises in STATUS/RDATA/END: normal, since the initiator raises nsync after ready. The current sequence completes.
- mem_ack arriving while mem_req=0: ignored.
- rst mid-transaction: immediate idle, bus released, mem_req dropped.

Optional Feature:
- Macro AUD_RMM_TARGET_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT/DRAIN.
  - When TIMEOUT_CYCLES elapse without mem_ack, drop mem_req.
  - In WAIT, drive status 0101; in DRAIN, go to IDLE.
- Undefined: no counter; wait indefinitely.

Decomposition:
- Shared package aud_pkg holds:
  - state encodings;
  - CMD bit positions (CMD_VALID=3, CMD_WRITE=2, size [1:0]);
  - size codes SZ_BYTE/SZ_WORD/SZ_LONG;
  - status nibbles ST_BUSY=0000, ST_READY=0001, ST_BUSERR=0011, ST_TIMEOUT=0101;
  - function nibbles(size).
- Sub-module aud_nibble_sreg: a 32-bit nibble load/extract register indexed by a 3-bit counter, instanced for addr, wdata and rdata.

Test Plan:
- Long write: cmd 1110, addr 0x1234_5678, data 0xDEAD_BEEF -> mem_req with we=1, size=2, addr 0x12345678, wdata 0xDEADBEEF; one oe=0 gap cycle; 0000 until ack; then 0001 for 1 cycle.
- Byte read: cmd 1000, addr 0x0000_0010, mem_rdata=0x0000_00A5, ack after 3 cycles -> 0000 x3, 0001, then nibbles 5, A; oe drops; IDLE after nsync high.
- Word read with mem_err=1 -> status 0011; no data nibbles; oe=0 next cycle.
- nsync rises after addr nibble 4 -> no mem_req, oe stays 0, busy clears within 1 cycle.
- Invalid cmd 0110 -> SKIP, no mem_req, oe never set; a following valid write is accepted normally.
- Timeout build, TIMEOUT_CYCLES=8, no ack -> mem_req drops after 8 cycles, status 0101. Separately, rst during RDATA -> all outputs 0 immediately.
